// File: rtl/falu_rs.sv
// rtl/falu_rs.sv - reservation station for the FP add/sub unit
// Collapsing queue (slot 0 oldest), CDB wakeup with dispatch bypass, oldest-ready issue.
module falu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 7,
    parameter int ROB_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [4:0]                   disp_funct5,
    input  logic [ROB_W-1:0]             disp_rob_idx,
    input  logic [TAG_W-1:0]             disp_rd,
    input  logic                         disp_rs1_rdy,
    input  logic [TAG_W-1:0]             disp_rs1_tag,
    input  logic [31:0]                  disp_rs1_data,
    input  logic                         disp_rs2_rdy,
    input  logic [TAG_W-1:0]             disp_rs2_tag,
    input  logic [31:0]                  disp_rs2_data,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic                         falu_i_valid,
    output logic [4:0]                   funct5,
    output logic [31:0]                  operand1,
    output logic [31:0]                  operand2,
    output logic [ROB_W-1:0]             falu_i_rob_idx,
    output logic [TAG_W-1:0]             falu_i_rd,
    output logic [$clog2(DEPTH+1)-1:0]   rs_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

    typedef struct packed {
        logic              vld;
        logic [4:0]        funct5;
        logic [ROB_W-1:0]  rob;
        logic [TAG_W-1:0]  rd;
        logic              rs1_rdy;
        logic [TAG_W-1:0]  rs1_tag;
        logic [31:0]       rs1_data;
        logic              rs2_rdy;
        logic [TAG_W-1:0]  rs2_tag;
        logic [31:0]       rs2_data;
    } ent_t;

    ent_t             r_ent  [DEPTH];
    ent_t             w_wake [DEPTH];
    ent_t             w_next [DEPTH];
    ent_t             w_disp;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_wr_idx;
    logic             r_disp_ready;
    logic             w_disp_acc;
    logic             w_issue;
    logic [SW-1:0]    w_sel_idx;
    logic [4:0]       w_sel_funct5;
    logic [31:0]      w_sel_op1;
    logic [31:0]      w_sel_op2;
    logic [ROB_W-1:0] w_sel_rob;
    logic [TAG_W-1:0] w_sel_rd;
    logic             r_falu_valid;
    logic [4:0]       r_funct5;
    logic [31:0]      r_operand1;
    logic [31:0]      r_operand2;
    logic [ROB_W-1:0] r_rob;
    logic [TAG_W-1:0] r_rd;

    assign w_disp_acc = disp_valid & r_disp_ready;

    // Descending scan so the last hit is the lowest (oldest) ready slot.
    always_comb begin
        w_issue      = 1'b0;
        w_sel_idx    = '0;
        w_sel_funct5 = '0;
        w_sel_op1    = '0;
        w_sel_op2    = '0;
        w_sel_rob    = '0;
        w_sel_rd     = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (r_ent[i].vld && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy) begin
                w_issue      = 1'b1;
                w_sel_idx    = SW'(i);
                w_sel_funct5 = r_ent[i].funct5;
                w_sel_op1    = r_ent[i].rs1_data;
                w_sel_op2    = r_ent[i].rs2_data;
                w_sel_rob    = r_ent[i].rob;
                w_sel_rd     = r_ent[i].rd;
            end
        end
    end

    always_comb begin
        w_disp          = '0;
        w_disp.vld      = 1'b1;
        w_disp.funct5   = disp_funct5;
        w_disp.rob      = disp_rob_idx;
        w_disp.rd       = disp_rd;
        w_disp.rs1_tag  = disp_rs1_tag;
        w_disp.rs2_tag  = disp_rs2_tag;
        w_disp.rs1_rdy  = disp_rs1_rdy | (cdb_valid && (cdb_tag == disp_rs1_tag));
        w_disp.rs2_rdy  = disp_rs2_rdy | (cdb_valid && (cdb_tag == disp_rs2_tag));
        w_disp.rs1_data = disp_rs1_rdy ? disp_rs1_data : cdb_data;
        w_disp.rs2_data = disp_rs2_rdy ? disp_rs2_data : cdb_data;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wake[i] = r_ent[i];
            if (cdb_valid && r_ent[i].vld) begin
                if (!r_ent[i].rs1_rdy && (r_ent[i].rs1_tag == cdb_tag)) begin
                    w_wake[i].rs1_rdy  = 1'b1;
                    w_wake[i].rs1_data = cdb_data;
                end
                if (!r_ent[i].rs2_rdy && (r_ent[i].rs2_tag == cdb_tag)) begin
                    w_wake[i].rs2_rdy  = 1'b1;
                    w_wake[i].rs2_data = cdb_data;
                end
            end
        end
    end

    // Collapse above the issued slot, then append the dispatch at the new tail.
    always_comb begin
        w_wr_idx     = r_count - CW'(w_issue);
        w_count_next = r_count + CW'(w_disp_acc) - CW'(w_issue);
        for (int i = 0; i < DEPTH-1; i++) begin
            w_next[i] = (w_issue && (SW'(i) >= w_sel_idx)) ? w_wake[i+1] : w_wake[i];
        end
        w_next[DEPTH-1] = w_issue ? '0 : w_wake[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (w_disp_acc && (CW'(i) == w_wr_idx)) begin
                w_next[i] = w_disp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count      <= '0;
            r_disp_ready <= 1'b1;
            r_falu_valid <= 1'b0;
            r_funct5     <= '0;
            r_operand1   <= '0;
            r_operand2   <= '0;
            r_rob        <= '0;
            r_rd         <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count      <= '0;
            r_disp_ready <= 1'b1;
            r_falu_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
            r_count      <= w_count_next;
            r_disp_ready <= (w_count_next < CW'(DEPTH));
            r_falu_valid <= w_issue;
            if (w_issue) begin
                r_funct5   <= w_sel_funct5;
                r_operand1 <= w_sel_op1;
                r_operand2 <= w_sel_op2;
                r_rob      <= w_sel_rob;
                r_rd       <= w_sel_rd;
            end
        end
    end

    assign disp_ready     = r_disp_ready;
    assign rs_count       = r_count;
    assign falu_i_valid   = r_falu_valid;
    assign funct5         = r_funct5;
    assign operand1       = r_operand1;
    assign operand2       = r_operand2;
    assign falu_i_rob_idx = r_rob;
    assign falu_i_rd      = r_rd;
endmodule
